// File: rtl/mask_compositor.sv
// mask_compositor: re-aligns an RGB pixel stream with its 1-bit background mask,
// replaces background pixels with a programmable fill colour and marks the last
// pixel of each frame on o_EOF.
// Optional per-frame foreground pixel count: define MASK_COMPOSITOR_STATS_EN.
// Without that macro o_FG_COUNT / o_FG_COUNT_VALID are tied to 0.
module mask_compositor #(
    parameter int unsigned MASK_LATENCY = 2,
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned CNT_W        = 19
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [23:0]       i_DATA_RGB,
    input  logic              i_DATA_VALID,
    input  logic              i_MASK,
    input  logic [23:0]       i_BG_COLOR,
    output logic [23:0]       o_DATA_RGB,
    output logic              o_DATA_VALID,
    output logic              o_EOF,
    output logic [CNT_W-1:0]  o_FG_COUNT,
    output logic              o_FG_COUNT_VALID
);

    localparam int unsigned RGB_W = 24;
    localparam int unsigned DLY_W = MASK_LATENCY * RGB_W;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    // Elaboration-time parameter legality
    generate
        if ((MASK_LATENCY < 1) || (MASK_LATENCY > 8)) begin : g_bad_latency
            $error("mask_compositor: MASK_LATENCY must be within 1..8");
        end
        if ((64'(1) << CNT_W) <= 64'(FRAME_PIXELS)) begin : g_bad_cnt_w
            $error("mask_compositor: CNT_W too narrow for FRAME_PIXELS");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Delay line: element 0 is the newest sample, element MASK_LATENCY-1
    // is the pixel whose mask bit is on i_MASK this cycle.
    // ------------------------------------------------------------------
    logic [MASK_LATENCY-1:0]            dly_v_q;
    logic [MASK_LATENCY-1:0]            dly_v_d;
    logic [MASK_LATENCY-1:0][RGB_W-1:0] dly_rgb_q;
    logic [MASK_LATENCY-1:0][RGB_W-1:0] dly_rgb_d;

    logic             d_valid;
    logic [RGB_W-1:0] d_rgb;

    // Shift every cycle, independent of valid, to track the classifier pipeline
    always_comb begin
        dly_v_d   = MASK_LATENCY'({dly_v_q, i_DATA_VALID});
        dly_rgb_d = DLY_W'({dly_rgb_q, i_DATA_RGB});
    end

    // Delay line registers
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            dly_v_q   <= '0;
            dly_rgb_q <= '0;
        end else begin
            dly_v_q   <= dly_v_d;
            dly_rgb_q <= dly_rgb_d;
        end
    end

    assign d_valid = dly_v_q[MASK_LATENCY-1];
    assign d_rgb   = dly_rgb_q[MASK_LATENCY-1];

    // ------------------------------------------------------------------
    // Composite stage and frame position counter
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0] rgb_d;
    logic             valid_q;
    logic             valid_d;
    logic             eof_q;
    logic             eof_d;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] pix_cnt_d;
    logic             last_pix_c;

    // Aligned pixel is the final one of its frame
    assign last_pix_c = d_valid && (pix_cnt_q == LAST_PIX);

    // Select pixel or fill colour; advance or wrap the frame position
    always_comb begin
        rgb_d     = rgb_q;
        valid_d   = d_valid;
        eof_d     = 1'b0;
        pix_cnt_d = pix_cnt_q;
        if (d_valid) begin
            rgb_d = i_MASK ? d_rgb : i_BG_COLOR;
            if (last_pix_c) begin
                eof_d     = 1'b1;
                pix_cnt_d = '0;
            end else begin
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
        end
    end

    // Composite stage registers
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rgb_q     <= '0;
            valid_q   <= 1'b0;
            eof_q     <= 1'b0;
            pix_cnt_q <= '0;
        end else begin
            rgb_q     <= rgb_d;
            valid_q   <= valid_d;
            eof_q     <= eof_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign o_DATA_RGB   = rgb_q;
    assign o_DATA_VALID = valid_q;
    assign o_EOF        = eof_q;

    // ------------------------------------------------------------------
    // Per-frame foreground statistics
    // ------------------------------------------------------------------
`ifdef MASK_COMPOSITOR_STATS_EN
    logic [CNT_W-1:0] fg_acc_q;
    logic [CNT_W-1:0] fg_acc_d;
    logic [CNT_W-1:0] fg_cnt_q;
    logic [CNT_W-1:0] fg_cnt_d;
    logic             fg_vld_q;
    logic             fg_vld_d;
    logic [CNT_W-1:0] fg_inc;

    assign fg_inc = CNT_W'(i_MASK);

    // Accumulate foreground pixels; publish and clear on the frame's last pixel
    always_comb begin
        fg_acc_d = fg_acc_q;
        fg_cnt_d = fg_cnt_q;
        fg_vld_d = 1'b0;
        if (d_valid) begin
            if (last_pix_c) begin
                fg_cnt_d = fg_acc_q + fg_inc;
                fg_acc_d = '0;
                fg_vld_d = 1'b1;
            end else begin
                fg_acc_d = fg_acc_q + fg_inc;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            fg_acc_q <= '0;
            fg_cnt_q <= '0;
            fg_vld_q <= 1'b0;
        end else begin
            fg_acc_q <= fg_acc_d;
            fg_cnt_q <= fg_cnt_d;
            fg_vld_q <= fg_vld_d;
        end
    end

    assign o_FG_COUNT       = fg_cnt_q;
    assign o_FG_COUNT_VALID = fg_vld_q;
`else
    assign o_FG_COUNT       = '0;
    assign o_FG_COUNT_VALID = 1'b0;
`endif

endmodule

// File: doc/mask_compositor.md
Name: mask_compositor

Overview:
- Consumes the 1-bit background mask produced by the max/min-difference classifier, together with the same RGB pixel stream that fed it.
- Delays the pixels internally so each one lines up with its mask bit.
- Outputs a composited stream: foreground pixels pass through, background pixels are replaced by a programmable fill colour.
- Counts pixel position within a frame; an optional block adds per-frame foreground statistics.

Parameters:
- MASK_LATENCY, 2: cycles from a pixel on i_DATA_RGB/i_DATA_VALID to its bit on i_MASK. Legal range 1..8.
- FRAME_PIXELS, 307200: valid pixels per frame (640x480).
- CNT_W, 19: width of the pixel and foreground counters. Must satisfy 2^CNT_W > FRAME_PIXELS.

Ports:
- i_CLK, in, 1: clock, rising edge.
- i_RST, in, 1: asynchronous active-high reset.
- i_DATA_RGB, in, 24: pixel packed {b,g,r}, 8 bits each.
- i_DATA_VALID, in, 1: pixel qualifier; gaps allowed on any cycle.
- i_MASK, in, 1: classifier output. 1 = foreground, 0 = background. Aligned MASK_LATENCY cycles after its pixel.
- i_BG_COLOR, in, 24: fill colour {b,g,r}. Sampled when a pixel is emitted.
- o_DATA_RGB, out, 24: composited pixel.
- o_DATA_VALID, out, 1: output qualifier.
- o_EOF, out, 1: high with the last pixel of a frame.
- o_FG_COUNT, out, CNT_W: foreground pixel count of the last completed frame.
- o_FG_COUNT_VALID, out, 1: one-cycle pulse when o_FG_COUNT updates.

Behaviour:
- Reset (async assert, sync release): all outputs 0, delay line contents and valids 0, pixel counter 0, foreground accumulator 0.
- Delay line:
  - MASK_LATENCY-deep shift register carrying {valid, rgb}. Shifts every cycle regardless of valid, so data and valid stay cycle-aligned with the classifier pipeline.
  - The tap at depth MASK_LATENCY is the aligned pixel (d_rgb, d_valid).
- Composite stage, registered output:
  - o_DATA_VALID <= d_valid.
  - o_DATA_RGB <= i_MASK ? d_rgb : i_BG_COLOR when d_valid = 1. Otherwise o_DATA_RGB holds its previous value.
  - Total latency from input pixel to output: MASK_LATENCY+1 cycles.
  - i_MASK is ignored on cycles where d_valid = 0.
- Pixel counter:
  - Increments on each emitted pixel (d_valid = 1).
  - When the counter equals FRAME_PIXELS-1 on an emitted pixel: o_EOF <= 1 for that output cycle, and the counter wraps to 0.
  - o_EOF = 0 on all other cycles, including invalid cycles.
  - Gaps in valid neither advance the counter nor clear it.
- No back-pressure: the block always accepts input and always emits. The downstream consumer must keep up.
- Reset mid-frame: pipeline contents are discarded and the counter restarts at 0. The next valid pixel after release is pixel 0 of a new frame.
- i_BG_COLOR may change at any time. It takes effect on the next emitted pixel; no frame-boundary latching.
- Without the optional feature: o_FG_COUNT = 0 and o_FG_COUNT_VALID = 0 permanently.

Optional Feature:
- Macro: MASK_COMPOSITOR_STATS_EN.
- When defined:
  - Foreground accumulator adds 1 for each emitted pixel with i_MASK = 1.
  - On the EOF pixel: o_FG_COUNT <= accumulator + (i_MASK ? 1 : 0) and o_FG_COUNT_VALID pulses for one cycle, coincident with o_EOF.
  - The accumulator clears to 0 in that same cycle.
  - o_FG_COUNT holds its value until the next EOF.
- When undefined:
  - Accumulator logic is absent.
  - Outputs are tied to 0 as stated above.

Test Plan:
- Reset then idle, i_RST high 13 ns then low, no valid -> all outputs 0 for 20 cycles; o_DATA_VALID never asserts.
- Latency/passthrough, MASK_LATENCY=2, pixel 0x123456 valid for one cycle, i_MASK=1 two cycles later -> o_DATA_VALID high exactly 3 cycles after input, o_DATA_RGB=0x123456.
- Background fill, i_BG_COLOR=0x00FF00, pixel 0xABCDEF with aligned i_MASK=0 -> o_DATA_RGB=0x00FF00. Same pixel with i_MASK=1 -> 0xABCDEF. i_MASK toggling on invalid cycles has no effect.
- Frame wrap with gaps, FRAME_PIXELS=8, 20 valid pixels interleaved with 5-cycle valid-low gaps -> o_EOF high on emitted pixels 8 and 16 only; counter does not move during gaps.
- Stats (STATS_EN), FRAME_PIXELS=8, mask pattern 1,0,1,1,0,0,1,1 -> o_FG_COUNT=5 with o_FG_COUNT_VALID pulse coincident with o_EOF. Next frame of all-0 masks -> o_FG_COUNT=0.
- Reset mid-frame, assert i_RST after 5 pixels of an 8-pixel frame, release, send 8 pixels -> o_EOF on the 8th post-reset pixel; no stale pixel is emitted after release.
